ifu_fetch: RTL
==============

// Module: ifu_fetch
// PURPOSE
//  Instruction fetch unit; sits directly upstream of the instruction RAM, which has a 1-cycle synchronous read.
//  Generates the next PC and read enable, consumes the returned {pc, inst} pair, and presents it to decode over valid/ready.
//  Also handles execute-stage redirects (jump/flush), decode back-pressure and misaligned-target traps.
// PARAMETERS
//  RST_PC  32'h0800_0000  boot PC (ISP region); must equal the RAM's reset PC
// PORTS
//  clk              in   1   clock
//  rst_n            in   1   reset, asynchronous, active-low
//  iram_rstn_i      in   1   RAM boot flag: high until first clk edge after reset (RAM self-reads RST_PC)
//  pc_i             in   32  PC of instruction currently on inst_i (from RAM)
//  inst_i           in   32  instruction word (from RAM)
//  pc_n_o           out  32  next fetch address (to RAM)
//  iram_rd_o        out  1   RAM read enable; low = RAM holds pc_i/inst_i
//  jump_en_i        in   1   redirect request from execute (flush younger)
//  jump_addr_i      in   32  redirect target
//  id_ready_i       in   1   decode accepts this cycle
//  id_valid_o       out  1   id_pc_o/id_inst_o valid
//  id_pc_o          out  32  = pc_i
//  id_inst_o        out  32  = inst_i
//  pred_taken_o     out  1   static prediction taken for current id_* instruction (0 without macro)
//  trap_misalign_o  out  1   1-cycle pulse: redirect target not word-aligned
//  trap_addr_o      out  32  offending target, held until next trap
// BEHAVIOUR
//  State: fv (fetch-valid reg) + FSM {BOOT, RUN, HALT}. Reset: state=BOOT, fv=0, trap_misalign_o=0, trap_addr_o=0.
//  Outputs combinational: id_valid_o = fv & ~jump_en_i & (state==RUN); id_pc_o=pc_i; id_inst_o=inst_i.
//  Reset values therefore: id_valid_o=0, iram_rd_o=0, pred_taken_o=0; pc_n_o=RST_PC.
//  BOOT: iram_rd_o=0 (RAM pc must stay RST_PC), pc_n_o=RST_PC. On edge with iram_rstn_i=1 -> RUN, fv<=1.
//  RUN, priority high->low:
//   1 jump_en_i & jump_addr_i[1:0]==0: iram_rd_o=1, pc_n_o=jump_addr_i; fv<=1. Current inst killed. 1 bubble.
//   2 jump_en_i & misaligned: iram_rd_o=0; fv<=0; trap_misalign_o<=1 next cycle, trap_addr_o<=jump_addr_i; -> HALT.
//   3 fv & ~id_ready_i (stall): iram_rd_o=0; fv holds; RAM holds outputs; id_* stable until accepted.
//   4 fv & id_ready_i: iram_rd_o=1, pc_n_o=next_pc; fv<=1. Back-to-back: 1 instr/cycle.
//   5 ~fv: iram_rd_o=1, pc_n_o=pc_i (refetch); fv<=1.
//  next_pc = pc_i + 4, 32-bit modulo (32'hFFFF_FFFC -> 0); or predicted target (see CONFIGURATION).
//  Jump during stall: jump wins, id_ready_i ignored. Jump and handshake same cycle: inst not delivered (id_valid_o=0).
//  HALT: iram_rd_o=0, id_valid_o=0; aligned jump_en_i -> case 1 and RUN; misaligned -> re-trap, stay HALT.
//  trap_misalign_o is 1 for exactly one cycle per misaligned request.
//  Reset mid-operation: async return to BOOT/fv=0; all in-flight fetches discarded.
// CONFIGURATION
//  IFU_BPU_EN defined: static predictor on inst_i when fv:
//   JAL (opcode 7'b1101111): target = pc_i + sext(imm_J), taken.
//   BRANCH (opcode 7'b1100011) with inst_i[31]=1 (backward): target = pc_i + sext(imm_B), taken.
//   Target bit[1]=1 -> not predicted. Taken: next_pc=target, pred_taken_o=1 with id_* of that instruction.
//   Execute must redirect on mispredict via jump_en_i.
//  IFU_BPU_EN undefined: next_pc = pc_i + 4 always; pred_taken_o tied 0; no decode logic.
// TESTING
//  1 Reset release, id_ready_i=1 -> cycle1 id_valid_o=1 id_pc_o=32'h0800_0000; then 0800_0004, 0800_0008 consecutive.
//  2 Hold id_ready_i=0 for 3 cycles at pc 0800_0008 -> iram_rd_o=0, id_pc_o/id_inst_o constant; release -> 0800_000C next.
//  3 jump_en_i, jump_addr_i=32'h0000_0100 while stalled -> id_valid_o=0 that cycle; next cycle id_pc_o=0000_0100.
//  4 jump_addr_i=32'h0000_0102 -> trap_misalign_o=1 one cycle, trap_addr_o=0000_0102, id_valid_o=0 until jump to 0000_0200.
//  5 pc_i=32'hFFFF_FFFC accepted -> pc_n_o=32'h0000_0000 (wrap).
//  6 IFU_BPU_EN: inst 32'hFE000EE3 (beq x0,x0,-4) at 0000_0010 -> pred_taken_o=1, next id_pc_o=0000_000C; undefined -> 0000_0014.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// Fetch-unit bundle: instruction RAM port, execute redirect, decode handshake and trap report.
// master = fetch unit, slave = surrounding pipeline/RAM.
interface ifu_fetch_if;
    logic        iram_rstn;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc_n;
    logic        iram_rd;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        pred_taken;
    logic        trap_misalign;
    logic [31:0] trap_addr;

    modport master (
        input  iram_rstn, pc, inst, jump_en, jump_addr, id_ready,
        output pc_n, iram_rd, id_valid, id_pc, id_inst, pred_taken, trap_misalign, trap_addr
    );

    modport slave (
        output iram_rstn, pc, inst, jump_en, jump_addr, id_ready,
        input  pc_n, iram_rd, id_valid, id_pc, id_inst, pred_taken, trap_misalign, trap_addr
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit in front of a 1-cycle synchronous instruction RAM.
// Optional static branch predictor enabled by defining IFU_BPU_EN.
module ifu_fetch #(
    parameter logic [31:0] RST_PC = 32'h0800_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    ifu_fetch_if.master   bus
);
    localparam int unsigned XLEN = 32;

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0]      state, state_n;
    logic            fv, fv_n;
    logic            trap_set;
    logic            trap_q;
    logic [XLEN-1:0] trap_addr_q;
    logic            rd;
    logic [XLEN-1:0] fetch_addr;
    logic [XLEN-1:0] next_pc;
    logic            pred;
    logic            jump_ok;

    assign jump_ok = (bus.jump_addr[1:0] == 2'b00);

`ifdef IFU_BPU_EN
    // Static predictor: JAL always taken, backward conditional branches taken.
    logic [XLEN-1:0] imm_j, imm_b, target;
    logic            is_jal, is_bbr;

    assign imm_j  = {{(XLEN-21){bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                     bus.inst[20], bus.inst[30:21], 1'b0};
    assign imm_b  = {{(XLEN-13){bus.inst[31]}}, bus.inst[31], bus.inst[7],
                     bus.inst[30:25], bus.inst[11:8], 1'b0};
    assign is_jal = (bus.inst[6:0] == 7'b1101111);
    assign is_bbr = (bus.inst[6:0] == 7'b1100011) && bus.inst[31];
    assign target = bus.pc + (is_jal ? imm_j : imm_b);
    assign pred   = fv && (state == RUN) && (is_jal || is_bbr) && !target[1];
    assign next_pc = pred ? target : bus.pc + XLEN'(4);
`else
    assign pred    = 1'b0;
    assign next_pc = bus.pc + XLEN'(4);
`endif

    // State, fetch-valid and trap registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            fv          <= 1'b0;
            trap_q      <= 1'b0;
            trap_addr_q <= '0;
        end else begin
            state  <= state_n;
            fv     <= fv_n;
            trap_q <= trap_set;
            if (trap_set) begin
                trap_addr_q <= bus.jump_addr;
            end
        end
    end

    // Next state and RAM request; redirects outrank the decode handshake
    always_comb begin
        state_n    = state;
        fv_n       = fv;
        trap_set   = 1'b0;
        rd         = 1'b0;
        fetch_addr = RST_PC;
        case (state)
            BOOT: begin
                if (bus.iram_rstn) begin
                    state_n = RUN;
                    fv_n    = 1'b1;
                end
            end
            RUN: begin
                if (bus.jump_en && jump_ok) begin
                    rd         = 1'b1;
                    fetch_addr = bus.jump_addr;
                    fv_n       = 1'b1;
                end else if (bus.jump_en) begin
                    fv_n     = 1'b0;
                    trap_set = 1'b1;
                    state_n  = HALT;
                end else if (fv && !bus.id_ready) begin
                    rd = 1'b0;
                end else if (fv) begin
                    rd         = 1'b1;
                    fetch_addr = next_pc;
                end else begin
                    rd         = 1'b1;
                    fetch_addr = bus.pc;
                    fv_n       = 1'b1;
                end
            end
            HALT: begin
                if (bus.jump_en && jump_ok) begin
                    rd         = 1'b1;
                    fetch_addr = bus.jump_addr;
                    fv_n       = 1'b1;
                    state_n    = RUN;
                end else if (bus.jump_en) begin
                    trap_set = 1'b1;
                end
            end
            default: begin
                state_n = BOOT;
                fv_n    = 1'b0;
            end
        endcase
    end

    assign bus.pc_n          = fetch_addr;
    assign bus.iram_rd       = rd;
    assign bus.id_valid      = fv && !bus.jump_en && (state == RUN);
    assign bus.id_pc         = bus.pc;
    assign bus.id_inst       = bus.inst;
    assign bus.pred_taken    = pred;
    assign bus.trap_misalign = trap_q;
    assign bus.trap_addr     = trap_addr_q;
endmodule
